// File: rtl/sram_like_arbiter_pkg.sv
// Shared CPU bus definitions for the sram-like arbiter slice.
//   SRC_INST / SRC_DATA : source tags stored in the response FIFO
//   size_e              : sram-like transfer size encodings
//   sram_req_t          : request payload muxed onto the master port
//   grant_e             : arbiter grant decision
package cpu_bus_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_INST,
    GNT_DATA
  } grant_e;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// sram-like bus bundle.
//   master : side issuing requests (drives req/wr/size/addr/wstrb/wdata)
//   slave  : side accepting requests (drives addr_ok/data_ok/rdata)
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter_tag_fifo.sv
// tag_fifo: 1-bit wide, DEPTH-deep synchronous FIFO of request source tags.
//   clk, reset      : rising-edge clock, async active-high reset
//   push_i, din_i   : write a tag at the tail (ignored when full)
//   pop_i           : advance the head (ignored when empty)
//   dout_o          : tag at the head
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored tags
module tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     din_i,
  input  logic                     pop_i,
  output logic                     dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[head_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[tail_q] <= din_i;
        tail_q        <= tail_q + PW'(1);
      end
      if (pop_ok) begin
        head_q <= head_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: 2:1 arbiter from CPU inst/data sram-like ports onto one
// sram-like master port. Data wins by default; an inst request losing
// STARVE_LIMIT consecutive cycles is forced to win next. Accepted requests
// push a source tag so in-order responses route back to their requester.
//   clk, reset : rising-edge clock, async active-high reset
//   inst, data : slave ports from the CPU core
//   m          : master port to the downstream sram-like target
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input logic                  clk,
  input logic                  reset,
  sram_like_arbiter_if.slave   inst,
  sram_like_arbiter_if.slave   data,
  sram_like_arbiter_if.master  m
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  grant_e        gnt;
  sram_req_t     inst_r, data_r, sel_r;
  logic          fifo_full, fifo_empty, head_tag;
  logic [CW-1:0] fifo_count_unused;
  logic          accept, resp, inst_acc;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_force_q, starve_force_d;

  assign inst_r = '{wr: inst.wr, size: inst.size, addr: inst.addr,
                    wstrb: inst.wstrb, wdata: inst.wdata};
  assign data_r = '{wr: data.wr, size: data.size, addr: data.addr,
                    wstrb: data.wstrb, wdata: data.wdata};

  always_comb begin
    gnt = GNT_NONE;
    if (starve_force_q && inst.req) gnt = GNT_INST;
    else if (data.req)              gnt = GNT_DATA;
    else if (inst.req)              gnt = GNT_INST;
  end

  // Fields follow data whenever inst is not the winner, including no grant.
  assign sel_r = (gnt == GNT_INST) ? inst_r : data_r;

  // Full blocks requests even when a pop lands in the same cycle, so there
  // is no combinational path from m.data_ok to m.req.
  assign m.req   = (inst.req | data.req) & ~fifo_full & ~reset;
  assign m.wr    = sel_r.wr;
  assign m.size  = sel_r.size;
  assign m.addr  = sel_r.addr;
  assign m.wstrb = sel_r.wstrb;
  assign m.wdata = sel_r.wdata;

  assign accept       = m.req & m.addr_ok;
  assign inst_acc     = accept & (gnt == GNT_INST);
  assign inst.addr_ok = inst_acc;
  assign data.addr_ok = accept & (gnt == GNT_DATA);

  assign resp         = m.data_ok & ~fifo_empty & ~reset;
  assign inst.data_ok = resp & (head_tag == SRC_INST);
  assign data.data_ok = resp & (head_tag == SRC_DATA);
  assign inst.rdata   = m.rdata;
  assign data.rdata   = m.rdata;

  tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .din_i   ((gnt == GNT_INST) ? SRC_INST : SRC_DATA),
    .pop_i   (resp),
    .dout_o  (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  // Force is raised from the next count so inst loses at most STARVE_LIMIT
  // cycles; the counter saturates to avoid wrapping while forced but stalled.
  always_comb begin
    starve_cnt_d   = starve_cnt_q;
    starve_force_d = starve_force_q;
    if (!inst.req || inst_acc)         starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + SW'(1);
    if (inst_acc)                        starve_force_d = 1'b0;
    else if (starve_cnt_d == STARVE_MAX) starve_force_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q   <= '0;
      starve_force_q <= 1'b0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      starve_force_q <= starve_force_d;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;
  import cpu_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if inst_bus ();
  sram_like_arbiter_if data_bus ();
  sram_like_arbiter_if m_bus ();

  sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_bus),
    .data  (data_bus),
    .m     (m_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = SIZE_WORD;
    inst_bus.addr = '0; inst_bus.wstrb = '0; inst_bus.wdata = '0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = SIZE_WORD;
    data_bus.addr = '0; data_bus.wstrb = '0; data_bus.wdata = '0;
    m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; m_bus.rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: every handshake output held low even with requests present.
    reset = 1'b1;
    idle_inputs();
    inst_bus.req = 1'b1; data_bus.req = 1'b1;
    m_bus.addr_ok = 1'b1; m_bus.data_ok = 1'b1;
    #3;
    chk("rst_m_req", m_bus.req, 0);
    chk("rst_inst_addr_ok", inst_bus.addr_ok, 0);
    chk("rst_data_addr_ok", data_bus.addr_ok, 0);
    chk("rst_inst_data_ok", inst_bus.data_ok, 0);
    chk("rst_data_data_ok", data_bus.data_ok, 0);
    chk("rst_count", dut.u_fifo.count_o, 0);
    chk("rst_force", dut.starve_force_q, 0);
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();

    // Simultaneous inst/data read: data first, then inst; responses in order.
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC00000;
    data_bus.req = 1'b1; data_bus.addr = 32'h80000010;
    m_bus.addr_ok = 1'b1;
    settle();
    chk("t1_m_req", m_bus.req, 1);
    chk("t1_m_addr_data", m_bus.addr, 32'h80000010);
    chk("t1_data_addr_ok", data_bus.addr_ok, 1);
    chk("t1_inst_addr_ok0", inst_bus.addr_ok, 0);
    tick();
    data_bus.req = 1'b0;
    settle();
    chk("t1_m_addr_inst", m_bus.addr, 32'hBFC00000);
    chk("t1_inst_addr_ok", inst_bus.addr_ok, 1);
    chk("t1_data_addr_ok0", data_bus.addr_ok, 0);
    chk("t1_count1", dut.u_fifo.count_o, 1);
    tick();
    inst_bus.req = 1'b0;
    m_bus.data_ok = 1'b1; m_bus.rdata = 32'h11111111;
    settle();
    chk("t1_count2", dut.u_fifo.count_o, 2);
    chk("t1_resp1_data", data_bus.data_ok, 1);
    chk("t1_resp1_inst", inst_bus.data_ok, 0);
    chk("t1_resp1_rdata", data_bus.rdata, 32'h11111111);
    tick();
    m_bus.rdata = 32'h22222222;
    settle();
    chk("t1_resp2_inst", inst_bus.data_ok, 1);
    chk("t1_resp2_data", data_bus.data_ok, 0);
    chk("t1_resp2_rdata", inst_bus.rdata, 32'h22222222);
    tick();
    m_bus.data_ok = 1'b0;
    settle();
    chk("t1_count0", dut.u_fifo.count_o, 0);

    // Starvation: inst loses 8 cycles to data, wins on the 9th.
    inst_bus.req = 1'b1; data_bus.req = 1'b1;
    m_bus.addr_ok = 1'b1; m_bus.data_ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      settle();
      if (k < 8) begin
        chk($sformatf("t2_data_win_%0d", k), data_bus.addr_ok, 1);
        chk($sformatf("t2_inst_lose_%0d", k), inst_bus.addr_ok, 0);
        if (k == 7) chk("t2_force_pre", dut.starve_force_q, 0);
      end else begin
        chk("t2_inst_forced", inst_bus.addr_ok, 1);
        chk("t2_data_lose", data_bus.addr_ok, 0);
        chk("t2_force_set", dut.starve_force_q, 1);
      end
      tick();
    end
    inst_bus.req = 1'b0; data_bus.req = 1'b0;
    settle();
    chk("t2_force_clr", dut.starve_force_q, 0);
    chk("t2_count", dut.u_fifo.count_o, 1);
    chk("t2_inst_resp", inst_bus.data_ok, 1);
    tick();
    m_bus.data_ok = 1'b0;
    settle();
    chk("t2_count0", dut.u_fifo.count_o, 0);

    // Fill to MAX_OUTSTANDING with writes; full blocks even with a same-cycle pop.
    data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.addr = 32'h80000100;
    data_bus.wstrb = 4'hF; data_bus.wdata = 32'hA5A5A5A5; data_bus.size = SIZE_HALF;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t3_accept_%0d", k), data_bus.addr_ok, 1);
      if (k == 0) begin
        chk("t3_m_wr", m_bus.wr, 1);
        chk("t3_m_wdata", m_bus.wdata, 32'hA5A5A5A5);
        chk("t3_m_wstrb", m_bus.wstrb, 4'hF);
        chk("t3_m_size", m_bus.size, SIZE_HALF);
      end
      tick();
    end
    settle();
    chk("t3_count4", dut.u_fifo.count_o, 4);
    chk("t3_full_m_req", m_bus.req, 0);
    chk("t3_full_addr_ok", data_bus.addr_ok, 0);
    m_bus.data_ok = 1'b1;
    settle();
    chk("t3_pop_m_req", m_bus.req, 0);
    chk("t3_pop_addr_ok", data_bus.addr_ok, 0);
    chk("t3_pop_data_ok", data_bus.data_ok, 1);
    tick();
    m_bus.data_ok = 1'b0;
    settle();
    chk("t3_count3", dut.u_fifo.count_o, 3);
    chk("t3_resume_m_req", m_bus.req, 1);
    chk("t3_resume_addr_ok", data_bus.addr_ok, 1);
    tick();
    idle_inputs();
    m_bus.data_ok = 1'b1;
    repeat (4) tick();
    m_bus.data_ok = 1'b0;
    settle();
    chk("t3_drained", dut.u_fifo.count_o, 0);

    // Interleaved inst, data, data, inst with push+pop overlap.
    m_bus.addr_ok = 1'b1;
    inst_bus.req = 1'b1;
    settle();
    chk("t4_inst_acc1", inst_bus.addr_ok, 1);
    tick();
    inst_bus.req = 1'b0; data_bus.req = 1'b1;
    settle();
    chk("t4_data_acc1", data_bus.addr_ok, 1);
    tick();
    m_bus.data_ok = 1'b1;
    settle();
    chk("t4_count_pre", dut.u_fifo.count_o, 2);
    chk("t4_data_acc2", data_bus.addr_ok, 1);
    chk("t4_resp_inst", inst_bus.data_ok, 1);
    chk("t4_resp_inst_n", data_bus.data_ok, 0);
    tick();
    data_bus.req = 1'b0; inst_bus.req = 1'b1;
    settle();
    chk("t4_count_pp1", dut.u_fifo.count_o, 2);
    chk("t4_inst_acc2", inst_bus.addr_ok, 1);
    chk("t4_resp_data1", data_bus.data_ok, 1);
    tick();
    inst_bus.req = 1'b0;
    settle();
    chk("t4_count_pp2", dut.u_fifo.count_o, 2);
    chk("t4_resp_data2", data_bus.data_ok, 1);
    chk("t4_resp_data2_n", inst_bus.data_ok, 0);
    tick();
    settle();
    chk("t4_resp_inst2", inst_bus.data_ok, 1);
    chk("t4_resp_inst2_n", data_bus.data_ok, 0);
    tick();
    m_bus.data_ok = 1'b0;
    settle();
    chk("t4_count0", dut.u_fifo.count_o, 0);

    // Spurious m_data_ok with nothing outstanding.
    m_bus.data_ok = 1'b1;
    settle();
    chk("t5_inst_data_ok", inst_bus.data_ok, 0);
    chk("t5_data_data_ok", data_bus.data_ok, 0);
    tick();
    m_bus.data_ok = 1'b0;
    settle();
    chk("t5_count0", dut.u_fifo.count_o, 0);

    // Reset with 3 outstanding drops them; stale responses are ignored.
    data_bus.req = 1'b1;
    tick();
    data_bus.req = 1'b0; inst_bus.req = 1'b1;
    tick();
    inst_bus.req = 1'b0; data_bus.req = 1'b1;
    tick();
    data_bus.req = 1'b0;
    settle();
    chk("t6_count3", dut.u_fifo.count_o, 3);
    reset = 1'b1;
    settle();
    chk("t6_rst_count", dut.u_fifo.count_o, 0);
    tick();
    reset = 1'b0;
    m_bus.data_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("t6_stale_inst_%0d", k), inst_bus.data_ok, 0);
      chk($sformatf("t6_stale_data_%0d", k), data_bus.data_ok, 0);
      tick();
    end
    m_bus.data_ok = 1'b0;
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC00004;
    settle();
    chk("t6_new_acc", inst_bus.addr_ok, 1);
    chk("t6_new_addr", m_bus.addr, 32'hBFC00004);
    tick();
    inst_bus.req = 1'b0;
    m_bus.data_ok = 1'b1; m_bus.rdata = 32'h33333333;
    settle();
    chk("t6_new_resp", inst_bus.data_ok, 1);
    chk("t6_new_rdata", inst_bus.rdata, 32'h33333333);
    tick();
    m_bus.data_ok = 1'b0;
    settle();
    chk("t6_count0", dut.u_fifo.count_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
